// File: rtl/grap_io_master.sv
// -----------------------------------------------------------------------------
// grap_io_master
//
// Host-side I/O initiator for the VGA graphics controller register file
// (GR00-GR08). A register read/write command from an internal requester is
// turned into host I/O cycles: an index write to 3CE followed by a data cycle
// on 3CF, or a single 16-bit write to 3CE carrying {data, index}. The data
// cycle completes on the graphics decoder's active-low ready. A strobe-cycle
// counter aborts a data cycle that never sees ready. The result is reported
// on a one-cycle response strobe.
//
// Optional feature (compile-time macro GRAP_IO_IDX_CACHE_EN):
//   Remembers the last index written to 3CE. An 8-bit command that targets
//   the same index skips the index cycle entirely. The cache is cleared by
//   reset and by any timeout. With the macro undefined, no cache is built and
//   every 8-bit command performs the index cycle.
//
// Ports:
//   h_hclk          host clock, rising edge
//   h_reset         asynchronous, active-high reset
//   cmd_valid/ready command handshake. A command is accepted on the rising
//                   edge where cmd_valid & cmd_ready are both 1. cmd_ready is
//                   1 only while idle. The cmd_* fields are sampled on that
//                   edge only and are not looked at again.
//   cmd_wr          1 = write, 0 = read
//   cmd_idx         graphics register index
//   cmd_data        write data
//   cmd_16          use one 16-bit write to 3CE (ignored for reads)
//   h_iord/h_iowr   I/O read/write strobes (never both high)
//   h_io_16         16-bit cycle qualifier
//   h_io_addr       I/O address (0 when no index/data cycle is running)
//   h_io_dbus_out   write data: [7:0] index, [15:8] data
//   h_io_dbus_in    read data (bus bits [15:8])
//   g_ready_n       active-low ready, only looked at during a data cycle
//   rsp_valid       one-cycle completion pulse
//   rsp_data        read data, echoed write data, or 8'hFF on timeout
//   rsp_err         timeout flag, qualified by rsp_valid
//   dbg_state_o     current FSM state, for observation only
//
// TIMEOUT_CYCLES (legal 2..255): the number of data strobe cycles allowed
// without ready before the cycle is aborted.
// -----------------------------------------------------------------------------
module grap_io_master #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        h_hclk,
    input  logic        h_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_idx,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_16,
    output logic        h_iord,
    output logic        h_iowr,
    output logic        h_io_16,
    output logic [15:0] h_io_addr,
    output logic [15:0] h_io_dbus_out,
    input  logic [7:0]  h_io_dbus_in,
    input  logic        g_ready_n,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [2:0]  dbg_state_o
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    // The counter value seen in the last permitted strobe cycle.
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_SAT  = CW'(TIMEOUT_CYCLES);
    localparam logic [15:0]     ADDR_IDX = 16'h03CE;
    localparam logic [15:0]     ADDR_DAT = 16'h03CF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IDX     = 3'd1,
        S_IDX_REC = 3'd2,
        S_DATA    = 3'd3,
        S_RSP     = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic          idx_ph_q, idx_ph_d;   // second cycle of the index write
    logic [CW-1:0] cnt_q, cnt_d;         // data strobe cycles already completed
    logic          wr_q, wr_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          is16_q, is16_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          cache_hit;

`ifdef GRAP_IO_IDX_CACHE_EN
    logic          cache_vld_q, cache_vld_d;
    logic [7:0]    cache_idx_q, cache_idx_d;

    assign cache_hit = cache_vld_q && (cache_idx_q == cmd_idx);
`else
    assign cache_hit = 1'b0;
`endif

    assign dbg_state_o = state_q;

    // Next-state and captured-command logic.
    always_comb begin
        state_d  = state_q;
        idx_ph_d = idx_ph_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        data_d   = data_q;
        is16_d   = is16_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef GRAP_IO_IDX_CACHE_EN
        cache_vld_d = cache_vld_q;
        cache_idx_d = cache_idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wr_d     = cmd_wr;
                    idx_d    = cmd_idx;
                    data_d   = cmd_data;
                    is16_d   = cmd_16 & cmd_wr;
                    cnt_d    = '0;
                    idx_ph_d = 1'b0;
                    err_d    = 1'b0;
                    if (cmd_16 & cmd_wr) begin
                        // The 16-bit write also loads the index register.
                        state_d = S_DATA;
`ifdef GRAP_IO_IDX_CACHE_EN
                        cache_vld_d = 1'b1;
                        cache_idx_d = cmd_idx;
`endif
                    end else if (cache_hit) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDX;
                    end
                end
            end
            S_IDX: begin
                // Fixed two-cycle index write, no ready wait.
                if (idx_ph_q) begin
                    state_d = S_IDX_REC;
`ifdef GRAP_IO_IDX_CACHE_EN
                    cache_vld_d = 1'b1;
                    cache_idx_d = idx_q;
`endif
                end else begin
                    idx_ph_d = 1'b1;
                end
            end
            S_IDX_REC: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                // Ready in the first strobe cycle is ignored so the target
                // always sees the strobe on at least two edges.
                if (!g_ready_n && (cnt_q != '0)) begin
                    state_d = S_RSP;
                    rdata_d = wr_q ? data_q : h_io_dbus_in;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RSP;
                    rdata_d = 8'hFF;
                    err_d   = 1'b1;
`ifdef GRAP_IO_IDX_CACHE_EN
                    // The target state is unknown after an abort.
                    cache_vld_d = 1'b0;
`endif
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the decoded next state.
    // As a result, outputs change on the same edge as the state they belong to.
    always_ff @(posedge h_hclk or posedge h_reset) begin
        if (h_reset) begin
            state_q       <= S_IDLE;
            idx_ph_q      <= 1'b0;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            idx_q         <= 8'h00;
            data_q        <= 8'h00;
            is16_q        <= 1'b0;
            rdata_q       <= 8'h00;
            err_q         <= 1'b0;
            cmd_ready     <= 1'b1;
            h_iord        <= 1'b0;
            h_iowr        <= 1'b0;
            h_io_16       <= 1'b0;
            h_io_addr     <= 16'h0000;
            h_io_dbus_out <= 16'h0000;
            rsp_valid     <= 1'b0;
            rsp_data      <= 8'h00;
            rsp_err       <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_ph_q <= idx_ph_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            is16_q   <= is16_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;

            cmd_ready     <= 1'b0;
            h_iord        <= 1'b0;
            h_iowr        <= 1'b0;
            h_io_16       <= 1'b0;
            h_io_addr     <= 16'h0000;
            h_io_dbus_out <= 16'h0000;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;

            case (state_d)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                end
                S_IDX: begin
                    h_iowr        <= 1'b1;
                    h_io_addr     <= ADDR_IDX;
                    h_io_dbus_out <= {8'h00, idx_d};
                end
                S_DATA: begin
                    if (is16_d) begin
                        h_iowr        <= 1'b1;
                        h_io_16       <= 1'b1;
                        h_io_addr     <= ADDR_IDX;
                        h_io_dbus_out <= {data_d, idx_d};
                    end else if (wr_d) begin
                        h_iowr        <= 1'b1;
                        h_io_addr     <= ADDR_DAT;
                        h_io_dbus_out <= {data_d, 8'h00};
                    end else begin
                        h_iord        <= 1'b1;
                        h_io_addr     <= ADDR_DAT;
                    end
                end
                S_RSP: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= rdata_d;
                    rsp_err   <= err_d;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GRAP_IO_IDX_CACHE_EN
    always_ff @(posedge h_hclk or posedge h_reset) begin
        if (h_reset) begin
            cache_vld_q <= 1'b0;
            cache_idx_q <= 8'h00;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_idx_q <= cache_idx_d;
        end
    end
`endif

endmodule

// File: tb/tb_grap_io_master.sv
// -----------------------------------------------------------------------------
// tb_grap_io_master
//
// Bench for grap_io_master. A simple graphics-decoder target model watches
// the data strobes and answers with ready on a chosen strobe cycle.
// Expected bus activity and responses come from a cycle-level description
// of the transaction: index phase, recovery, data length, response.
// -----------------------------------------------------------------------------
module tb_grap_io_master;

  localparam int TO = 15;
`ifdef GRAP_IO_IDX_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        h_hclk = 1'b0;
  logic        h_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_idx;
  logic [7:0]  cmd_data;
  logic        cmd_16;
  logic        h_iord;
  logic        h_iowr;
  logic        h_io_16;
  logic [15:0] h_io_addr;
  logic [15:0] h_io_dbus_out;
  logic [7:0]  h_io_dbus_in;
  logic        g_ready_n;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [2:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 h_hclk = ~h_hclk;

  grap_io_master #(.TIMEOUT_CYCLES(TO)) dut (
    .h_hclk        (h_hclk),
    .h_reset       (h_reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_wr        (cmd_wr),
    .cmd_idx       (cmd_idx),
    .cmd_data      (cmd_data),
    .cmd_16        (cmd_16),
    .h_iord        (h_iord),
    .h_iowr        (h_iowr),
    .h_io_16       (h_io_16),
    .h_io_addr     (h_io_addr),
    .h_io_dbus_out (h_io_dbus_out),
    .h_io_dbus_in  (h_io_dbus_in),
    .g_ready_n     (g_ready_n),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .dbg_state_o   (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-cycle trace, index k = k-th cycle after the accept edge.
  // tr_bus = {iord, iowr, io_16, addr[15:0], dbus_out[15:0]}
  logic [34:0] tr_bus [64];
  logic [9:0]  tr_rsp [64];   // {rsp_valid, rsp_err, rsp_data}
  logic        tr_rdy [64];

  // Target model state
  int         tgt_cnt;
  int         tgt_r;      // strobe cycle on which ready is given; 0 = never
  logic [7:0] tgt_rd;

  // Reference index-cache model and scoreboard
  logic       mc_vld;
  logic [7:0] mc_idx;
  logic [7:0] exp_q[$];

  function automatic logic [34:0] bus(input logic rd, input logic wr, input logic b16,
                                      input logic [15:0] a, input logic [15:0] d);
    return {rd, wr, b16, a, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick_sample(input int k);
    @(negedge h_hclk);
    tr_bus[k] = {h_iord, h_iowr, h_io_16, h_io_addr, h_io_dbus_out};
    tr_rsp[k] = {rsp_valid, rsp_err, rsp_data};
    tr_rdy[k] = cmd_ready;
    if ((h_iord || h_iowr) && (h_io_addr == 16'h03CF || h_io_16)) begin
      tgt_cnt++;
      if (tgt_r != 0 && tgt_cnt >= tgt_r) begin
        g_ready_n    = 1'b0;
        h_io_dbus_in = tgt_rd;
      end else begin
        g_ready_n    = 1'b1;
        h_io_dbus_in = 8'($urandom);
      end
    end else begin
      tgt_cnt      = 0;
      g_ready_n    = 1'($urandom);
      h_io_dbus_in = 8'($urandom);
    end
  endtask

  task automatic reset_dut();
    @(negedge h_hclk);
    h_reset = 1'b1;
    cmd_valid = 1'b0;
    @(negedge h_hclk);
    @(negedge h_hclk);
    h_reset = 1'b0;
    mc_vld  = 1'b0;
    tgt_cnt = 0;
  endtask

  // Issues one command (DUT assumed idle) and records the trace until the
  // cycle after the response, or 63 cycles.
  task automatic do_cmd(input logic wr, input logic [7:0] idx, input logic [7:0] data,
                        input logic c16, input int r, input logic [7:0] rd, output int lat);
    tgt_r   = r;
    tgt_rd  = rd;
    tgt_cnt = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_idx   = idx;
    cmd_data  = data;
    cmd_16    = c16;
    @(posedge h_hclk);
    #1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_idx   = 8'($urandom);
    cmd_data  = 8'($urandom);
    cmd_16    = 1'($urandom);
    lat = -1;
    for (int k = 1; k < 64; k++) begin
      tick_sample(k);
      if (tr_rsp[k][9] && lat < 0) lat = k;
      if (lat > 0 && k == lat + 1) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge h_hclk);
    @(negedge h_hclk);
    n_cmp++;
    if ({h_iord, h_iowr, h_io_16} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {h_iord, h_iowr, h_io_16});
    end
    n_cmp++;
    if ({h_io_addr, h_io_dbus_out} !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h want 00000000", {h_io_addr, h_io_dbus_out});
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data} !== 10'h0) begin
      n_fail++; $display("FAIL reset_rsp: got %h want 000", {rsp_valid, rsp_err, rsp_data});
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    h_reset = 1'b0;
    @(negedge h_hclk);
    n_cmp++;
    if ({cmd_ready, h_iord, h_iowr, rsp_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL post_reset_idle: got %b want 1000", {cmd_ready, h_iord, h_iowr, rsp_valid});
    end
  endtask

  task automatic test_write8();
    int lat;
    logic [34:0] e;
    do_cmd(1'b1, 8'h05, 8'h5A, 1'b0, 2, 8'h00, lat);
    n_cmp++;
    if (lat !== 6) begin n_fail++; $display("FAIL w8_latency: got %0d want 6", lat); end
    for (int k = 1; k <= 6; k++) begin
      e = (k <= 2) ? bus(1'b0, 1'b1, 1'b0, 16'h03CE, 16'h0005) :
          (k == 3 || k == 6) ? 35'h0 : bus(1'b0, 1'b1, 1'b0, 16'h03CF, 16'h5A00);
      n_cmp++;
      if (tr_bus[k] !== e) begin
        n_fail++; $display("FAIL w8_bus[%0d]: got %h want %h", k, tr_bus[k], e);
      end
    end
    n_cmp++;
    if (tr_rsp[6] !== {1'b1, 1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL w8_rsp: got %h want 25a", tr_rsp[6]);
    end
    n_cmp++;
    if (tr_rdy[7] !== 1'b1) begin n_fail++; $display("FAIL w8_ready_after: got %b want 1", tr_rdy[7]); end
  endtask

  task automatic test_read8();
    int lat;
    logic [34:0] e;
    do_cmd(1'b0, 8'h08, 8'h77, 1'b0, 2, 8'hC3, lat);
    n_cmp++;
    if (lat !== 6) begin n_fail++; $display("FAIL r8_latency: got %0d want 6", lat); end
    for (int k = 1; k <= 6; k++) begin
      e = (k <= 2) ? bus(1'b0, 1'b1, 1'b0, 16'h03CE, 16'h0008) :
          (k == 3 || k == 6) ? 35'h0 : bus(1'b1, 1'b0, 1'b0, 16'h03CF, 16'h0000);
      n_cmp++;
      if (tr_bus[k] !== e) begin
        n_fail++; $display("FAIL r8_bus[%0d]: got %h want %h", k, tr_bus[k], e);
      end
    end
    n_cmp++;
    if (tr_rsp[6] !== {1'b1, 1'b0, 8'hC3}) begin
      n_fail++; $display("FAIL r8_rsp: got %h want 2c3", tr_rsp[6]);
    end
  endtask

  task automatic test_write16();
    int lat;
    logic [34:0] e;
    do_cmd(1'b1, 8'h03, 8'h1F, 1'b1, 2, 8'h00, lat);
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL w16_latency: got %0d want 3", lat); end
    for (int k = 1; k <= 3; k++) begin
      e = (k <= 2) ? bus(1'b0, 1'b1, 1'b1, 16'h03CE, 16'h1F03) : 35'h0;
      n_cmp++;
      if (tr_bus[k] !== e) begin
        n_fail++; $display("FAIL w16_bus[%0d]: got %h want %h", k, tr_bus[k], e);
      end
    end
    n_cmp++;
    if (tr_rsp[3] !== {1'b1, 1'b0, 8'h1F}) begin
      n_fail++; $display("FAIL w16_rsp: got %h want 21f", tr_rsp[3]);
    end
    n_cmp++;
    if (tr_rdy[4] !== 1'b1) begin n_fail++; $display("FAIL w16_ready_after: got %b want 1", tr_rdy[4]); end
  endtask

  task automatic test_timeout();
    int lat;
    int dcnt;
    do_cmd(1'b1, 8'h07, 8'h33, 1'b0, 0, 8'h00, lat);
    n_cmp++;
    if (lat !== 19) begin n_fail++; $display("FAIL tmo_latency: got %0d want 19", lat); end
    dcnt = 0;
    for (int k = 1; k < 64; k++)
      if (k <= 19 && tr_bus[k] === bus(1'b0, 1'b1, 1'b0, 16'h03CF, 16'h3300)) dcnt++;
    n_cmp++;
    if (dcnt !== TO) begin n_fail++; $display("FAIL tmo_data_len: got %0d want %0d", dcnt, TO); end
    n_cmp++;
    if (tr_rsp[19] !== {1'b1, 1'b1, 8'hFF}) begin
      n_fail++; $display("FAIL tmo_rsp: got %h want 3ff", tr_rsp[19]);
    end
    // Next command completes normally and, having lost the cached index,
    // goes through the index cycle again.
    do_cmd(1'b0, 8'h07, 8'h00, 1'b0, 2, 8'h96, lat);
    n_cmp++;
    if (lat !== 6) begin n_fail++; $display("FAIL tmo_next_latency: got %0d want 6", lat); end
    n_cmp++;
    if (tr_rsp[6] !== {1'b1, 1'b0, 8'h96}) begin
      n_fail++; $display("FAIL tmo_next_rsp: got %h want 296", tr_rsp[6]);
    end
  endtask

  task automatic test_reset_during_data();
    int seen;
    int notrdy;
    tgt_r = 0; tgt_cnt = 0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_idx = 8'h09; cmd_data = 8'h44; cmd_16 = 1'b0;
    @(posedge h_hclk);
    #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) tick_sample(k);
    n_cmp++;
    if (tr_bus[5] !== bus(1'b0, 1'b1, 1'b0, 16'h03CF, 16'h4400)) begin
      n_fail++; $display("FAIL rst_mid_pre: got %h want %h", tr_bus[5], bus(1'b0, 1'b1, 1'b0, 16'h03CF, 16'h4400));
    end
    h_reset = 1'b1;
    #1;
    n_cmp++;
    if ({h_iord, h_iowr, h_io_16, cmd_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL rst_mid_immediate: got %b want 0001", {h_iord, h_iowr, h_io_16, cmd_ready});
    end
    @(negedge h_hclk);
    @(negedge h_hclk);
    h_reset = 1'b0;
    mc_vld  = 1'b0;
    seen = 0; notrdy = 0;
    for (int k = 1; k <= 8; k++) begin
      tick_sample(k);
      if (tr_rsp[k][9]) seen++;
      if (tr_rdy[k] !== 1'b1) notrdy++;
    end
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_rsp: got %0d pulses want 0", seen); end
    n_cmp++;
    if (notrdy !== 0) begin n_fail++; $display("FAIL rst_mid_ready: got %0d not-ready cycles want 0", notrdy); end
  endtask

  task automatic test_cache();
    int lat1, lat2, n3ce, exp_lat, exp_3ce;
    reset_dut();
    do_cmd(1'b0, 8'h04, 8'h00, 1'b0, 2, 8'h21, lat1);
    n_cmp++;
    if (lat1 !== 6) begin n_fail++; $display("FAIL cache_first_latency: got %0d want 6", lat1); end
    do_cmd(1'b0, 8'h04, 8'h00, 1'b0, 2, 8'h22, lat2);
    exp_lat = CACHE_EN ? 3 : 6;
    exp_3ce = CACHE_EN ? 0 : 2;
    n_cmp++;
    if (lat2 !== exp_lat) begin n_fail++; $display("FAIL cache_second_latency: got %0d want %0d", lat2, exp_lat); end
    n3ce = 0;
    for (int k = 1; k <= 6; k++)
      if (k <= lat2 && tr_bus[k][33] && tr_bus[k][31:16] == 16'h03CE) n3ce++;
    n_cmp++;
    if (n3ce !== exp_3ce) begin n_fail++; $display("FAIL cache_3ce_cycles: got %0d want %0d", n3ce, exp_3ce); end
    n_cmp++;
    if (lat2 > 0 && tr_rsp[lat2] !== {1'b1, 1'b0, 8'h22}) begin
      n_fail++; $display("FAIL cache_second_rsp: got %h want 222", tr_rsp[lat2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] e;
    logic        ev;
    tgt_r = 2; tgt_rd = 8'h00; tgt_cnt = 0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_idx = 8'h0A; cmd_data = 8'h6B; cmd_16 = 1'b1;
    @(posedge h_hclk);
    #1;
    for (int k = 1; k <= 7; k++) tick_sample(k);
    cmd_valid = 1'b0;
    tick_sample(8);
    for (int k = 1; k <= 7; k++) begin
      e  = (k == 1 || k == 2 || k == 5 || k == 6) ? bus(1'b0, 1'b1, 1'b1, 16'h03CE, 16'h6B0A) : 35'h0;
      ev = (k == 3 || k == 7);
      n_cmp++;
      if ({tr_bus[k], tr_rsp[k][9]} !== {e, ev}) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h/%b want %h/%b", k, tr_bus[k], tr_rsp[k][9], e, ev);
      end
    end
    n_cmp++;
    if (tr_rdy[4] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_gap: got %b want 1", tr_rdy[4]); end
  endtask

  task automatic test_random();
    logic       wr, c16, c16w, hit, tmo;
    logic [7:0] idx, data, rd, ed;
    int         r, pre, len, exp_lat, lat;
    logic [34:0] e, edat;
    logic [9:0]  er;
    reset_dut();
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      c16  = 1'($urandom_range(0, 1));
      idx  = 8'($urandom_range(0, 3));
      data = 8'($urandom);
      rd   = 8'($urandom);
      r    = $urandom_range(0, 17);
      c16w = c16 & wr;
      hit  = CACHE_EN && !c16w && mc_vld && (mc_idx == idx);
      pre  = (c16w || hit) ? 0 : 3;
      tmo  = (r == 0 || r > TO);
      len  = tmo ? TO : ((r < 2) ? 2 : r);
      exp_lat = pre + len + 1;
      exp_q.push_back(tmo ? 8'hFF : (wr ? data : rd));
      if (!hit) begin mc_vld = 1'b1; mc_idx = idx; end
      if (tmo) mc_vld = 1'b0;
      edat = c16w ? bus(1'b0, 1'b1, 1'b1, 16'h03CE, {data, idx}) :
             wr   ? bus(1'b0, 1'b1, 1'b0, 16'h03CF, {data, 8'h00}) :
                    bus(1'b1, 1'b0, 1'b0, 16'h03CF, 16'h0000);
      do_cmd(wr, idx, data, c16, r, rd, lat);
      n_cmp++;
      if (lat !== exp_lat) begin
        n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, exp_lat);
      end
      for (int k = 1; k <= exp_lat; k++) begin
        if (pre == 3 && k <= 2)      e = bus(1'b0, 1'b1, 1'b0, 16'h03CE, {8'h00, idx});
        else if (pre == 3 && k == 3) e = 35'h0;
        else if (k <= pre + len)     e = edat;
        else                         e = 35'h0;
        n_cmp++;
        if ({tr_bus[k], tr_rsp[k][9]} !== {e, (k == exp_lat)}) begin
          n_fail++; $display("FAIL rnd%0d_cyc[%0d]: got %h/%b want %h/%b", n, k, tr_bus[k], tr_rsp[k][9], e, (k == exp_lat));
        end
      end
      ed = exp_q.pop_front();
      er = {1'b1, tmo, ed};
      n_cmp++;
      if (tr_rsp[exp_lat] !== er) begin
        n_fail++; $display("FAIL rnd%0d_rsp: got %h want %h", n, tr_rsp[exp_lat], er);
      end
      n_cmp++;
      if (tr_rdy[exp_lat + 1] !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_ready_after: got %b want 1", n, tr_rdy[exp_lat + 1]);
      end
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    h_reset      = 1'b1;
    cmd_valid    = 1'b0;
    cmd_wr       = 1'b0;
    cmd_idx      = 8'h00;
    cmd_data     = 8'h00;
    cmd_16       = 1'b0;
    g_ready_n    = 1'b1;
    h_io_dbus_in = 8'h00;
    tgt_cnt      = 0;
    tgt_r        = 0;
    tgt_rd       = 8'h00;
    mc_vld       = 1'b0;
    mc_idx       = 8'h00;
    test_reset();
    test_write8();
    test_read8();
    test_write16();
    test_timeout();
    test_reset_during_data();
    test_cache();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/grap_io_master.md
# grap_io_master

Host-side I/O initiator for the VGA graphics controller register file (GR00–GR08). It accepts register read/write commands from an internal requester (BIOS shadow loader, mode-set sequencer) and turns them into host I/O cycles on ports 3CE (index) and 3CF (data), with an optional single 16-bit write to 3CE. It completes each data cycle on the graphics decoder's `g_ready_n` handshake and reports the result on a one-cycle response strobe, with a timeout guard.

## Interface
- `TIMEOUT_CYCLES`, 15: strobe cycles allowed in a data cycle without ready before the cycle is aborted; legal range 2..255.

- `h_hclk` in 1: host clock; all logic on the rising edge.
- `h_reset` in 1: **one clock; reset is asynchronous and active-high**.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block idle; a command is accepted on the edge where `cmd_valid & cmd_ready`.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_idx` in 8: graphics register index.
- `cmd_data` in 8: write data.
- `cmd_16` in 1: use a single 16-bit write to 3CE. Ignored for reads.
- `h_iord` out 1: I/O read strobe.
- `h_iowr` out 1: I/O write strobe.
- `h_io_16` out 1: 16-bit cycle qualifier.
- `h_io_addr` out 16: I/O address.
- `h_io_dbus_out` out 16: write data; [7:0] carries the index, [15:8] carries the data.
- `h_io_dbus_in` in 8: read data, bus bits [15:8].
- `g_ready_n` in 1: active-low ready from the graphics decoder.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: read data, or the echoed write data.
- `rsp_err` out 1: timeout flag, qualified by `rsp_valid`.

## Operation
- States: IDLE, IDX, IDX_REC, DATA, RSP.
- **IDLE**
  - `cmd_ready`=1.
  - On accept, capture `cmd_*`. The command fields are not sampled again.
  - If `cmd_16 & cmd_wr`, go to DATA in 16-bit form; otherwise go to IDX.
- **IDX**
  - `h_iowr`=1, `h_io_addr`=16'h03CE, `h_io_16`=0, `h_io_dbus_out`={8'h00, idx}.
  - Held for exactly 2 cycles, with no ready wait. Then go to IDX_REC.
- **IDX_REC**
  - 1 cycle, all strobes 0. Then go to DATA.
- **DATA, 8-bit form**
  - `h_io_addr`=16'h03CF.
  - Write: `h_iowr`=1, `h_io_dbus_out`={data, 8'h00}.
  - Read: `h_iord`=1, `h_io_dbus_out`=0.
- **DATA, 16-bit form**
  - `h_io_addr`=16'h03CE, `h_io_16`=1, `h_iowr`=1, `h_io_dbus_out`={data, idx}.
- **DATA completion**
  - Strobe counter starts at 0 on entry.
  - The cycle completes on the edge where `g_ready_n`=0 and the counter is ≥1. The minimum strobe length is 2 cycles, so the target always sees the strobe on two consecutive edges.
  - A read captures `h_io_dbus_in` on that edge.
  - If the counter reaches `TIMEOUT_CYCLES` without ready, the cycle is aborted. It then completes with error.
- **RSP**
  - Strobes 0, `rsp_valid`=1 for one cycle, then go to IDLE.
  - `rsp_data`: captured read data, or `cmd_data` for writes, or 8'hFF on timeout.
  - `rsp_err`=1 only on timeout.
- **Outputs outside IDX/DATA:** `h_io_addr`, `h_io_dbus_out`, `h_io_16` = 0.
- **Signal rules**
  - `h_iord` and `h_iowr` are never both 1.
  - `g_ready_n` is ignored outside DATA.
  - `g_ready_n`=0 on the first DATA cycle does not complete the cycle.
- **Counter:** width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates.

## Timing
- **Reset values (asynchronous, immediate):**
  - state IDLE, `cmd_ready`=1.
  - `h_iord`, `h_iowr`, `h_io_16`, `rsp_valid`, `rsp_err` = 0.
  - `h_io_addr`, `h_io_dbus_out`, `rsp_data` = 0.
  - Index cache invalid.
- **8-bit write with ready on the second strobe cycle** (accept at edge T0):
  - IDX: T0+1..T0+2.
  - IDX_REC: T0+3.
  - DATA: T0+4..T0+5.
  - RSP: T0+6.
  - `cmd_ready` high at T0+7.
- **8-bit read:** same timing as the 8-bit write.
- **16-bit write:** DATA T0+1..T0+2, RSP T0+3.
- **Late ready:** each additional cycle of `g_ready_n` high extends DATA by 1 cycle.
- **Reset mid-operation:** strobes drop in the same cycle, the command is discarded, and no `rsp_valid` is issued.
- **Back-to-back commands:** `cmd_valid` held high is accepted at the first IDLE edge. There is always at least 1 all-strobes-0 cycle (RSP) between consecutive bus cycles.

## Configuration
- `GRAP_IO_IDX_CACHE_EN` defined:
  - An 8-bit register plus a valid bit holds the last index written to 3CE, by either an IDX cycle or a 16-bit write.
  - An 8-bit command whose `cmd_idx` equals the valid cached index skips IDX/IDX_REC and goes straight to DATA. Accept at T0 gives DATA at T0+1.
  - The cache is invalidated by reset and by any timeout.
- `GRAP_IO_IDX_CACHE_EN` undefined:
  - No cache is built.
  - Every 8-bit command performs the IDX cycle.

## Test plan
- **8-bit write:** write idx 8'h05, data 8'h5A; target asserts `g_ready_n`=0 from the second strobe cycle. Required:
  - 3CE carries 8'h05 for 2 cycles.
  - One idle cycle follows.
  - 3CF carries 8'h5A for 2 cycles.
  - `rsp_valid` at T0+6 with `rsp_data`=8'h5A, `rsp_err`=0.
- **8-bit read:** read idx 8'h08; target drives `h_io_dbus_in`=8'hC3 with ready. Required:
  - `h_iord` is high only in DATA.
  - `rsp_data`=8'hC3.
- **16-bit write:** `cmd_16`=1, idx 8'h03, data 8'h1F. Required:
  - A single 2-cycle cycle at 3CE with `h_io_16`=1 and `h_io_dbus_out`=16'h1F03.
  - `rsp_valid` at T0+3.
- **Timeout:** `g_ready_n` held 1. Required:
  - DATA lasts exactly 15 cycles.
  - `rsp_err`=1, `rsp_data`=8'hFF.
  - The next command is accepted normally.
- **Reset during DATA:** assert `h_reset` on the second DATA cycle. Required:
  - Strobes are 0 in the same cycle.
  - No `rsp_valid`.
  - `cmd_ready`=1 after release.
- **Index cache (macro defined):** two reads of idx 8'h04. Required:
  - The second read has no 3CE cycle and responds at T0+3.
  - With the macro undefined, the second read responds at T0+6.
